// File: rtl/sprite_ram_loader.sv
// Writes a valid/ready stream of 8-bit palette indices into the sprite RAM in raster order.
// Writes can be held off until vblank, and the block reports done and a running checksum.
module sprite_ram_loader #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 256,
    parameter int ADDR_WIDTH  = 15,
    parameter bit WAIT_VBLANK = 1'b1
) (
    input  logic                  pixel_clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  vblank,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           checksum
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | accepting pixels into the RAM
    // DONE   | one-cycle marker after the last pixel
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] count;
    logic                  xfer;

    // start takes priority so a restart never lands a stray pixel at the old address
    assign in_ready = (state == S_LOAD) && !start && (vblank || !WAIT_VBLANK);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            count    <= '0;
            we       <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            checksum <= 16'd0;
        end else begin
            we <= 1'b0;
            if (start) begin
                state    <= S_LOAD;
                count    <= '0;
                checksum <= 16'd0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (xfer) begin
                            we       <= 1'b1;
                            wr_addr  <= count;
                            wr_data  <= in_data;
                            checksum <= checksum + {8'd0, in_data};
                            // the counter stops at the last address instead of wrapping
                            if (count == LAST_ADDR) begin
                                state <= S_DONE;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
